pipe_ctrl_seq: RTL and testbench
================================

Name: pipe_ctrl_seq

Overview:
- Parametrised pipeline stall/flush controller for the in-order core.
- Generalises the fixed 5-stage combinational controller to NSTAGE stages.
- Adds a sequenced exception path: a multi-cycle flush hold, a captured redirect PC, and a redirect handshake with fetch.
- Sits beside the pipeline registers and drives stall_o/flush_o into every stage register.

Parameters:
- NSTAGE, 5, number of pipeline stages; index 0 = PC/fetch, NSTAGE-1 = writeback.
- FLUSH_HOLD, 1, cycles all-stage flush stays asserted after an exception is accepted (>=1).
- PC_W, 32, redirect PC width.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- streq_i  in  NSTAGE  per-stage stall request; bit i from stage i
- exc_flag_i  in  1  exception/ERET commit pulse from the memory stage
- exc_pc_i  in  PC_W  handler/return PC, valid with exc_flag_i
- redirect_ack_i  in  1  fetch has accepted redirect_pc_o
- stall_o  out  NSTAGE  per-stage hold
- flush_o  out  NSTAGE  per-stage bubble insert/clear
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  PC_W  captured target PC
- busy_o  out  1  FSM not in IDLE
- perf_stall_o  out  CNT_W  stall-cycle counter (see Optional Feature)
- perf_exc_o  out  CNT_W  accepted-exception counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, hold counter=0, redirect_valid_o=0, redirect_pc_o=0, perf counters=0.
  - stall_o and flush_o evaluate to 0, since streq_i is ignored while rst=1.
- Priority vector (combinational): s[i] = OR of streq_i[j] for j>=i.
  - A downstream requester stalls itself and every upstream stage.
- IDLE, exc_flag_i=0:
  - stall_o[i] = s[i] for i<NSTAGE-1; stall_o[NSTAGE-1] = 0 (writeback never stalls).
  - flush_o[i] = s[i-1] & ~s[i] for i>=1; flush_o[0] = 0. This inserts one bubble at the stall boundary.
- IDLE, exc_flag_i=1 (same cycle, combinational):
  - stall_o = 0, flush_o = all ones; streq_i is overridden.
  - On the clock edge: capture exc_pc_i into redirect_pc_o, counter=FLUSH_HOLD-1, and go to FLUSH if FLUSH_HOLD>1, else REDIRECT.
- FLUSH:
  - stall_o = 0, flush_o = all ones.
  - Counter decrements each cycle; at 0 the next state is REDIRECT.
- REDIRECT:
  - redirect_valid_o = 1, redirect_pc_o held stable.
  - stall_o[0] = 1 (fetch held); other stalls follow the priority vector.
  - flush_o[0] = 1; other flushes follow the IDLE rule.
  - redirect_ack_i=1 moves the FSM to IDLE, with redirect_valid_o=0 on the next cycle.
- Nested exception (exc_flag_i=1 in FLUSH or REDIRECT, including the same cycle as redirect_ack_i):
  - Exception wins: recapture exc_pc_i, reload the counter, and re-enter FLUSH/REDIRECT per FLUSH_HOLD.
  - flush_o = all ones that cycle.
- busy_o = (state != IDLE).
- Reset mid-operation: immediate return to IDLE; redirect_valid_o drops asynchronously.
- Latency:
  - Exception to redirect_valid_o = FLUSH_HOLD cycles.
  - Stall and bubble paths have zero latency (combinational from streq_i).
- NSTAGE=5, FLUSH_HOLD=1, IDLE matches the legacy 5-stage controller bit-for-bit.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_o increments on every cycle where any stall_o bit is 1.
  - perf_exc_o increments on every accepted exc_flag_i.
  - Both are saturating at all-ones and cleared only by rst.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the FSM state enum (IDLE, FLUSH, REDIRECT, 2-bit encoding);
  - default localparams for NSTAGE/PC_W;
  - a stage-index constant per stage name (PC, ID, EX, MEM, WB).
- One sub-module, pipe_ctrl_prio: purely combinational, parametrised by NSTAGE. It turns streq_i into the priority vector s and the bubble vector.

Test Plan:
- Priority stall: NSTAGE=5, streq_i=5'b00100 in IDLE -> stall_o=5'b00111, flush_o=5'b01000.
- Writeback request: streq_i=5'b10000 -> stall_o=5'b01111, flush_o=5'b00000.
- Exception with hold: FLUSH_HOLD=3, exc_flag_i=1, exc_pc_i=0xBFC00380 ->
  - flush_o=5'b11111 for 3 cycles;
  - then redirect_valid_o=1, redirect_pc_o=0xBFC00380, stall_o[0]=1;
  - redirect_ack_i on cycle 6 -> busy_o=0 on cycle 7.
- Nested exception: during REDIRECT, exc_flag_i=1 with exc_pc_i=0x80000180 and redirect_ack_i=1 ->
  - FSM re-enters FLUSH, redirect_pc_o=0x80000180, redirect_valid_o=0 for FLUSH_HOLD cycles.
- Async reset in FLUSH: rst pulse mid-cycle -> busy_o=0, redirect_valid_o=0 and redirect_pc_o=0 immediately, without waiting for a clock edge.
- Perf (PIPE_CTRL_PERF_EN, CNT_W=4):
  - 20 stall cycles -> perf_stall_o=4'hF (saturates);
  - 2 exceptions -> perf_exc_o=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Holds the sequencer state encoding and the named stage indices.
package pipe_ctrl_pkg;

    localparam int DEF_NSTAGE = 5;
    localparam int DEF_PC_W   = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef enum int {
        STG_PC  = 0,
        STG_ID  = 1,
        STG_EX  = 2,
        STG_MEM = 3,
        STG_WB  = 4
    } stage_t;

endpackage

// File: rtl/pipe_ctrl_prio.sv
// Combinational stall priority: a request from stage i holds stage i and
// every stage upstream of it; the bubble vector marks the stage just past the boundary.
module pipe_ctrl_prio #(
    parameter int NSTAGE = 5
) (
    input  logic [NSTAGE-1:0] streq,
    output logic [NSTAGE-1:0] prio,
    output logic [NSTAGE-1:0] bubble
);

    always_comb begin
        logic acc;
        acc    = 1'b0;
        prio   = '0;
        bubble = '0;
        // Sweep from writeback toward fetch so each stage sees every downstream request.
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc     = acc | streq[i];
            prio[i] = acc;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            bubble[i] = prio[i-1] & ~prio[i];
        end
    end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Parametrised stall/flush controller with a sequenced exception/redirect path.
// Optional saturating performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE     = DEF_NSTAGE,
    parameter int FLUSH_HOLD = 1,
    parameter int PC_W       = DEF_PC_W,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] streq_i,
    input  logic              exc_flag_i,
    input  logic [PC_W-1:0]   exc_pc_i,
    input  logic              redirect_ack_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic              redirect_valid_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  perf_stall_o,
    output logic [CNT_W-1:0]  perf_exc_o
);

    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_HOLD - 1);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [NSTAGE-1:0] streq_eff;
    logic [NSTAGE-1:0] prio;
    logic [NSTAGE-1:0] bubble;
    logic              exc;

    // Inputs are masked during reset so the combinational outputs read zero.
    assign streq_eff = rst ? '0 : streq_i;
    assign exc       = exc_flag_i & ~rst;

    pipe_ctrl_prio #(
        .NSTAGE(NSTAGE)
    ) u_prio (
        .streq (streq_eff),
        .prio  (prio),
        .bubble(bubble)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pc_o <= '0;
        end else if (exc) begin
            redirect_pc_o <= exc_pc_i;
        end
    end

    // An exception overrides every state, including a same-cycle redirect ack;
    // the stale redirect is withdrawn that cycle so fetch cannot accept it.
    always_comb begin
        state_nxt           = state;
        hold_nxt            = hold_cnt;
        stall_o             = prio;
        stall_o[NSTAGE-1]   = 1'b0;
        flush_o             = bubble;
        redirect_valid_o    = 1'b0;
        if (exc) begin
            state_nxt = (FLUSH_HOLD > 1) ? FLUSH : REDIRECT;
            hold_nxt  = HOLD_LOAD;
            stall_o   = '0;
            flush_o   = '1;
        end else begin
            case (state)
                IDLE: begin
                end
                FLUSH: begin
                    stall_o = '0;
                    flush_o = '1;
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state_nxt = REDIRECT;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt - HOLD_W'(1);
                    end
                end
                REDIRECT: begin
                    redirect_valid_o = 1'b1;
                    stall_o[STG_PC]  = 1'b1;
                    flush_o[STG_PC]  = 1'b1;
                    if (redirect_ack_i) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != IDLE);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] exc_cnt;

    // Both counters stick at all-ones until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            exc_cnt   <= '0;
        end else begin
            if ((|stall_o) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (exc && (exc_cnt != '1)) begin
                exc_cnt <= exc_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_o = stall_cnt;
    assign perf_exc_o   = exc_cnt;
`else
    assign perf_stall_o = '0;
    assign perf_exc_o   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Self-checking bench for pipe_ctrl_seq: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_pipe_ctrl_seq;

    localparam int N     = 5;
    localparam int HOLD  = 3;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic [N-1:0]     streq  = '0;
    logic             exc    = 1'b0;
    logic [PC_W-1:0]  exc_pc = '0;
    logic             ack    = 1'b0;

    logic [N-1:0]     stall_o;
    logic [N-1:0]     flush_o;
    logic             redirect_valid_o;
    logic [PC_W-1:0]  redirect_pc_o;
    logic             busy_o;
    logic [CNT_W-1:0] perf_stall_o;
    logic [CNT_W-1:0] perf_exc_o;

    int checks = 0;
    int errors = 0;

    // Model: an outstanding exception and how many edges have passed since it.
    logic            m_active = 1'b0;
    int              m_age    = 0;
    logic [PC_W-1:0] m_pc     = '0;
    int              m_nstall = 0;
    int              m_nexc   = 0;

    pipe_ctrl_seq #(
        .NSTAGE    (N),
        .FLUSH_HOLD(HOLD),
        .PC_W      (PC_W),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .streq_i         (streq),
        .exc_flag_i      (exc),
        .exc_pc_i        (exc_pc),
        .redirect_ack_i  (ack),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .busy_o          (busy_o),
        .perf_stall_o    (perf_stall_o),
        .perf_exc_o      (perf_exc_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic e,
                                 input logic [PC_W-1:0] pc, input logic a);
        @(posedge clk);
        #1;
        streq  = r;
        exc    = e;
        exc_pc = pc;
        ack    = a;
    endtask

    function automatic int top_req(input logic [N-1:0] r);
        int h;
        h = -1;
        for (int i = 0; i < N; i++) if (r[i]) h = i;
        return h;
    endfunction

    // Everything at or below the furthest-downstream requester holds, except writeback.
    function automatic logic [N-1:0] idle_stall(input logic [N-1:0] r);
        int h;
        h = top_req(r);
        if (h < 0) return '0;
        return N'((1 << (h + 1)) - 1) & ~N'(1 << (N - 1));
    endfunction

    function automatic logic [N-1:0] idle_flush(input logic [N-1:0] r);
        int h;
        h = top_req(r);
        if (h >= 0 && h < N - 1) return N'(1 << (h + 1));
        return '0;
    endfunction

    function automatic logic exc_now();
        return exc && !rst;
    endfunction

    function automatic logic in_flush_window();
        return m_active && (m_age < HOLD);
    endfunction

    function automatic logic [N-1:0] exp_stall();
        logic [N-1:0] s;
        if (rst || exc_now() || in_flush_window()) return '0;
        s = idle_stall(streq);
        if (m_active) s[0] = 1'b1;
        return s;
    endfunction

    function automatic logic [N-1:0] exp_flush();
        logic [N-1:0] f;
        if (rst) return '0;
        if (exc_now() || in_flush_window()) return '1;
        f = idle_flush(streq);
        if (m_active) f[0] = 1'b1;
        return f;
    endfunction

    function automatic logic exp_valid();
        return !rst && !exc_now() && m_active && (m_age >= HOLD);
    endfunction

    function automatic int sat(input int n);
`ifdef PIPE_CTRL_PERF_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return 0 * n;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_age    = 0;
            m_pc     = '0;
            m_nstall = 0;
            m_nexc   = 0;
        end else begin
            if (|exp_stall()) m_nstall++;
            if (exc) begin
                m_active = 1'b1;
                m_age    = 1;
                m_pc     = exc_pc;
                m_nexc++;
            end else if (m_active && m_age >= HOLD && ack) begin
                m_active = 1'b0;
            end else if (m_active && m_age < HOLD) begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("stall", stall_o, exp_stall());
        checkOutput("flush", flush_o, exp_flush());
        checkOutput("redirect_valid", redirect_valid_o, exp_valid());
        checkOutput("redirect_pc", redirect_pc_o, m_pc);
        checkOutput("busy", busy_o, m_active);
        checkOutput("perf_stall", perf_stall_o, CNT_W'(sat(m_nstall)));
        checkOutput("perf_exc", perf_exc_o, CNT_W'(sat(m_nexc)));
    end

    initial begin
        logic [N-1:0] r;
        $display("[TB] start");
        #1 rst = 1'b1;

        applyStimulus('1, 1'b1, 32'hDEADBEEF, 1'b1);
        #2;
        checkOutput("rst_stall", stall_o, 5'b00000);
        checkOutput("rst_flush", flush_o, 5'b00000);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_valid", redirect_valid_o, 1'b0);
        checkOutput("rst_pc", redirect_pc_o, 32'h0);

        applyStimulus('0, 1'b0, '0, 1'b0);
        rst = 1'b0;

        applyStimulus(5'b00100, 1'b0, '0, 1'b0);
        #2;
        checkOutput("prio_stall", stall_o, 5'b00111);
        checkOutput("prio_flush", flush_o, 5'b01000);
        applyStimulus(5'b10000, 1'b0, '0, 1'b0);
        #2;
        checkOutput("wb_stall", stall_o, 5'b01111);
        checkOutput("wb_flush", flush_o, 5'b00000);

        applyStimulus(5'b00110, 1'b1, 32'hBFC00380, 1'b0);
        #2;
        checkOutput("exc_flush", flush_o, 5'b11111);
        checkOutput("exc_stall", stall_o, 5'b00000);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(N'($urandom), 1'b0, '0, 1'b0);
            #2;
            checkOutput("hold_flush", flush_o, 5'b11111);
            checkOutput("hold_valid", redirect_valid_o, 1'b0);
        end
        applyStimulus('0, 1'b0, '0, 1'b0);
        #2;
        checkOutput("redir_valid", redirect_valid_o, 1'b1);
        checkOutput("redir_pc", redirect_pc_o, 32'hBFC00380);
        checkOutput("redir_stall", stall_o, 5'b00001);
        checkOutput("redir_flush", flush_o, 5'b00001);
        applyStimulus('0, 1'b0, '0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b1);
        #2;
        checkOutput("ack_busy", busy_o, 1'b1);
        applyStimulus('0, 1'b0, '0, 1'b0);
        #2;
        checkOutput("post_ack_busy", busy_o, 1'b0);
        checkOutput("post_ack_valid", redirect_valid_o, 1'b0);

        applyStimulus('0, 1'b1, 32'h12345678, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0);
        applyStimulus(5'b01000, 1'b1, 32'h80000180, 1'b1);
        #2;
        checkOutput("nest_flush", flush_o, 5'b11111);
        for (int k = 0; k < 2; k++) begin
            applyStimulus('0, 1'b0, '0, 1'b1);
            #2;
            checkOutput("nest_busy", busy_o, 1'b1);
            checkOutput("nest_valid", redirect_valid_o, 1'b0);
            checkOutput("nest_pc", redirect_pc_o, 32'h80000180);
        end
        applyStimulus('0, 1'b0, '0, 1'b0);
        #2;
        checkOutput("nest_redir_valid", redirect_valid_o, 1'b1);

        applyStimulus('0, 1'b1, 32'hA5A5A5A5, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("pre_rst_busy", busy_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_busy", busy_o, 1'b0);
        checkOutput("arst_valid", redirect_valid_o, 1'b0);
        checkOutput("arst_pc", redirect_pc_o, 32'h0);
        rst = 1'b0;

        applyStimulus('0, 1'b1, 32'h00001000, 1'b0);
        repeat (3) applyStimulus('0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("pre_rst_valid", redirect_valid_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_redir_valid", redirect_valid_o, 1'b0);
        rst = 1'b0;

        repeat (20) applyStimulus(N'($urandom_range(1, 31)), 1'b0, '0, 1'b0);
        #2;
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf_stall_sat", perf_stall_o, 4'hF);
`else
        checkOutput("perf_stall_off", perf_stall_o, 4'h0);
`endif
        for (int k = 0; k < 2; k++) begin
            applyStimulus('0, 1'b1, $urandom, 1'b0);
            repeat (3) applyStimulus('0, 1'b0, '0, 1'b0);
            applyStimulus('0, 1'b0, '0, 1'b1);
        end
        applyStimulus('0, 1'b0, '0, 1'b0);
        #2;
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf_exc_two", perf_exc_o, 4'd2);
`else
        checkOutput("perf_exc_off", perf_exc_o, 4'd0);
`endif

        for (int k = 0; k < 400; k++) begin
            r = N'($urandom);
            applyStimulus(r, ($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 99) == 0);
        end
        applyStimulus('0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        repeat (3) applyStimulus('0, 1'b0, '0, 1'b1);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
